// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared up-FSM encoding and width/one-hot helpers for the calendar key router
package calendar_pkg;

  localparam int MAX_CHANNELS = 64;

  typedef enum logic [1:0] {
    UP_IDLE   = 2'd0,
    UP_HOLD   = 2'd1,
    UP_REPEAT = 2'd2,
    UP_LOCK   = 2'd3
  } up_state_e;

  function automatic int mode_width(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Callers cast the result down to their own channel count.
  function automatic logic [MAX_CHANNELS-1:0] onehot(input int unsigned idx);
    return {{(MAX_CHANNELS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stability counter and rising-edge flag for one button
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the cycle the count would reach DEBOUNCE_CYCLES,
  // giving 2 + DEBOUNCE_CYCLES cycles from raw change to level change.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/key_router_n.sv
// rtl/key_router_n.sv - N-channel calendar key router with mode cycling, one-shot and auto-repeat pulses
module key_router_n
  import calendar_pkg::*;
#(
  parameter  int CHANNELS        = 3,
  parameter  int DEBOUNCE_CYCLES = 250000,
  parameter  int HOLD_CYCLES     = 25000000,
  parameter  int REPEAT_CYCLES   = 5000000,
  localparam int MW              = mode_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                on_off,
  input  logic                mode_key,
  input  logic                up_key,
  output logic [CHANNELS-1:0] up,
  output logic [CHANNELS-1:0] select,
  output logic [MW-1:0]       mode
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [MW-1:0] MODE_LAST   = MW'(CHANNELS - 1);

  logic mode_rise, mode_level_unused;
  logic up_rise, up_level;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW             (CW)
  ) u_mode_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (mode_key),
    .level(mode_level_unused),
    .rise (mode_rise)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW             (CW)
  ) u_up_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (up_key),
    .level(up_level),
    .rise (up_rise)
  );

  up_state_e           state_q, state_d;
  logic [CW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [MW-1:0]       mode_q, mode_d;
  logic [CHANNELS-1:0] up_q, up_d;
  logic [CHANNELS-1:0] select_q, select_d;
  logic                pulse;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    pulse      = 1'b0;
    if (!on_off) begin
      state_d    = UP_IDLE;
      hold_cnt_d = '0;
    end else begin
      if (mode_rise) begin
        mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
      end
      unique case (state_q)
        UP_IDLE: begin
          if (up_rise) begin
            pulse      = 1'b1;
            hold_cnt_d = '0;
            state_d    = mode_rise ? UP_LOCK : UP_HOLD;
          end
        end
        UP_HOLD, UP_REPEAT: begin
          // A channel change ends auto-repeat until the key is released.
          if (!up_level) begin
            state_d    = UP_IDLE;
            hold_cnt_d = '0;
          end else if (mode_rise) begin
            state_d    = UP_LOCK;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == ((state_q == UP_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            pulse      = 1'b1;
            hold_cnt_d = '0;
            state_d    = UP_REPEAT;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end
        UP_LOCK: begin
          if (!up_level) begin
            state_d = UP_IDLE;
          end
        end
        default: state_d = UP_IDLE;
      endcase
    end
    // Pulses route by the pre-update mode; select tracks the post-update mode.
    up_d     = pulse ? CHANNELS'(onehot(32'(mode_q))) : '0;
    select_d = on_off ? CHANNELS'(onehot(32'(mode_d))) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UP_IDLE;
      hold_cnt_q <= '0;
      mode_q     <= '0;
      up_q       <= '0;
      select_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      up_q       <= up_d;
      select_q   <= select_d;
    end
  end

  assign up     = up_q;
  assign select = select_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_key_router_n.sv
// tb/tb_key_router_n.sv - directed table-driven bench for key_router_n
module tb_key_router_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       on_off = 1'b1;
  logic       mode_key = 1'b0;
  logic       up_key = 1'b0;
  logic [2:0] up, select;
  logic [1:0] mode;

  key_router_n #(
    .CHANNELS       (3),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .on_off  (on_off),
    .mode_key(mode_key),
    .up_key  (up_key),
    .up      (up),
    .select  (select),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int         npulse, first_p, bad_oh;
  logic [2:0] up_or;
  int         pulse_q[$];
  int         exp_q[$];

  // Cycle c drives inputs, then samples 1 time unit after edge c+1.
  task automatic run_seq(input int ncyc, input int up_on, input int up_off,
                         input int md_on, input int md_off,
                         input int off_from, input int off_to);
    npulse  = 0;
    first_p = -1;
    bad_oh  = 0;
    up_or   = '0;
    pulse_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      up_key   = (c >= up_on && c < up_off);
      mode_key = (c >= md_on && c < md_off);
      on_off   = !(c >= off_from && c < off_to);
      @(posedge clk);
      #1;
      if (up != 3'b000) begin
        npulse++;
        pulse_q.push_back(c + 1);
        if (first_p < 0) first_p = c + 1;
        up_or = up_or | up;
        if (!$onehot(up)) bad_oh++;
      end
    end
    up_key   = 1'b0;
    mode_key = 1'b0;
    on_off   = 1'b1;
  endtask

  task automatic check_pulses(input string name);
    chk({name, "_count"}, pulse_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++) begin
      chk($sformatf("%s_at%0d", name, i), pulse_q[i], exp_q[i]);
    end
  endtask

  typedef struct {
    int         ncyc, up_on, up_off, md_on, md_off, off_from, off_to;
    int         npulse, first_c;
    logic [2:0] upor;
    logic [1:0] mode;
    logic [2:0] sel;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{20,  0,  8, -1, -1, -1, -1, 1,  7, 3'b001, 2'd0, 3'b001};
    vecs[1]  = '{20,  0,  3, -1, -1, -1, -1, 0, -1, 3'b000, 2'd0, 3'b001};
    vecs[2]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd1, 3'b010};
    vecs[3]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd2, 3'b100};
    vecs[4]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd0, 3'b001};
    vecs[5]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd1, 3'b010};
    vecs[6]  = '{20,  0,  8, -1, -1, -1, -1, 1,  7, 3'b010, 2'd1, 3'b010};
    vecs[7]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd2, 3'b100};
    vecs[8]  = '{20, -1, -1,  0,  8, -1, -1, 0, -1, 3'b000, 2'd0, 3'b001};
    vecs[9]  = '{20,  0,  8,  0,  8, -1, -1, 1,  7, 3'b001, 2'd1, 3'b010};
    vecs[10] = '{20,  2, 10,  2, 10,  0, 20, 0, -1, 3'b000, 2'd1, 3'b000};
    vecs[11] = '{35,  0, 20, -1, -1,  0, 10, 0, -1, 3'b000, 2'd1, 3'b010};
    vecs[12] = '{20,  0,  8, -1, -1, -1, -1, 1,  7, 3'b010, 2'd1, 3'b010};

    // Reset state, then first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up", up, 3'b000);
    chk("rst_sel", select, 3'b000);
    chk("rst_mode", mode, 2'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_up", up, 3'b000);
    chk("post_rst_sel", select, 3'b001);
    chk("post_rst_mode", mode, 2'd0);

    // Auto-repeat on channel 0 with a 30-cycle hold.
    run_seq(45, 0, 30, -1, -1, -1, -1);
    exp_q = '{7, 17, 20, 23, 26, 29, 32, 35};
    check_pulses("repeat");
    chk("repeat_upor", up_or, 3'b001);
    chk("repeat_onehot", bad_oh, 0);

    for (int i = 0; i < 13; i++) begin
      run_seq(vecs[i].ncyc, vecs[i].up_on, vecs[i].up_off, vecs[i].md_on,
              vecs[i].md_off, vecs[i].off_from, vecs[i].off_to);
      chk($sformatf("v%0d_npulse", i), npulse, vecs[i].npulse);
      chk($sformatf("v%0d_first", i), first_p, vecs[i].first_c);
      chk($sformatf("v%0d_upor", i), up_or, vecs[i].upor);
      chk($sformatf("v%0d_mode", i), mode, vecs[i].mode);
      chk($sformatf("v%0d_sel", i), select, vecs[i].sel);
      chk($sformatf("v%0d_onehot", i), bad_oh, 0);
    end

    // Back to channel 0, then a mode press during auto-repeat.
    run_seq(20, -1, -1, 0, 8, -1, -1);
    run_seq(20, -1, -1, 0, 8, -1, -1);
    chk("lock_pre_mode", mode, 2'd0);
    run_seq(60, 0, 50, 23, 31, -1, -1);
    exp_q = '{7, 17, 20, 23, 26, 29};
    check_pulses("lock");
    chk("lock_upor", up_or, 3'b001);
    chk("lock_mode", mode, 2'd1);
    run_seq(20, 0, 8, -1, -1, -1, -1);
    exp_q = '{7};
    check_pulses("after_lock");
    chk("after_lock_upor", up_or, 3'b010);

    // Asynchronous reset in the middle of auto-repeat on channel 1.
    up_key = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_up", up, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("async_up", up, 3'b000);
    chk("async_sel", select, 3'b000);
    chk("async_mode", mode, 2'd0);
    up_key = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq(20, -1, -1, -1, -1, -1, -1);
    chk("post_async_npulse", npulse, 0);
    chk("post_async_mode", mode, 2'd0);
    chk("post_async_sel", select, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
